// File: rtl/vga_scanout.sv
// vga_scanout: scans a 160x120x3 framebuffer out as 640x480@60 VGA with 4x4 pixel replication.
// Counters tick at 25 MHz via pix_en; pins lag the counters by a matched 2-tick pipeline.
module vga_scanout #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] x_v,
    input  logic [6:0] y_v,
    input  logic [2:0] c_v,
    input  logic       plot,
    output logic       frame_done,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [9:0] VGA_R,
    output logic [9:0] VGA_G,
    output logic [9:0] VGA_B
);
    localparam logic [9:0] H_V    = 10'(H_VIS);
    localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_V    = 10'(V_VIS);
    localparam logic [9:0] V_VL   = 10'(V_VIS - 1);
    localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

    logic [2:0]  mem [0:19199];
    logic [2:0]  rd_q;
    logic [14:0] rd_addr, wr_addr;
    logic        wr_ok, vis;
    logic        pix_en_q, pix_en_d;
    logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic        hs1_q, hs1_d, vs1_q, vs1_d, vis1_q, vis1_d;
    logic        hs2_q, hs2_d, vs2_q, vs2_d, blank2_q, blank2_d;
    logic [2:0]  rgb_q, rgb_d;
    logic        frame_done_q, frame_done_d;

    assign vis     = (h_cnt_q < H_V) && (v_cnt_q < V_V);
    assign rd_addr = vis ? 15'(v_cnt_q[9:2]) * 15'd160 + 15'(h_cnt_q[9:2]) : 15'd0;
    assign wr_addr = 15'(y_v) * 15'd160 + 15'(x_v);
    assign wr_ok   = plot && (x_v < 8'd160) && (y_v < 7'd120);

    always_comb begin
        pix_en_d     = ~pix_en_q;
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        hs1_d        = hs1_q;
        vs1_d        = vs1_q;
        vis1_d       = vis1_q;
        hs2_d        = hs2_q;
        vs2_d        = vs2_q;
        blank2_d     = blank2_q;
        rgb_d        = rgb_q;
        frame_done_d = pix_en_q && (h_cnt_q == H_LAST) && (v_cnt_q == V_VL);
        if (pix_en_q) begin
            h_cnt_d  = (h_cnt_q == H_LAST) ? 10'd0 : h_cnt_q + 10'd1;
            v_cnt_d  = (h_cnt_q != H_LAST) ? v_cnt_q : (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            hs1_d    = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
            vs1_d    = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
            vis1_d   = vis;
            hs2_d    = hs1_q;
            vs2_d    = vs1_q;
            blank2_d = vis1_q;
            rgb_d    = vis1_q ? rd_q : 3'd0;
        end
    end

    // Framebuffer: write port free-running, read port advances with pix_en; a colliding read sees old data.
    always_ff @(posedge CLOCK_50) begin
        if (wr_ok) mem[wr_addr] <= c_v;
        if (pix_en_q) rd_q <= mem[rd_addr];
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pix_en_q     <= 1'b0;
            h_cnt_q      <= 10'd0;
            v_cnt_q      <= 10'd0;
            hs1_q        <= 1'b1;
            vs1_q        <= 1'b1;
            vis1_q       <= 1'b0;
            hs2_q        <= 1'b1;
            vs2_q        <= 1'b1;
            blank2_q     <= 1'b0;
            rgb_q        <= 3'd0;
            frame_done_q <= 1'b0;
        end else begin
            pix_en_q     <= pix_en_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            hs1_q        <= hs1_d;
            vs1_q        <= vs1_d;
            vis1_q       <= vis1_d;
            hs2_q        <= hs2_d;
            vs2_q        <= vs2_d;
            blank2_q     <= blank2_d;
            rgb_q        <= rgb_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_done  = frame_done_q;
    assign VGA_CLK     = pix_en_q;
    assign VGA_HS      = hs2_q;
    assign VGA_VS      = vs2_q;
    assign VGA_BLANK_N = blank2_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = {10{rgb_q[2]}};
    assign VGA_G       = {10{rgb_q[1]}};
    assign VGA_B       = {10{rgb_q[0]}};
endmodule
